// File: rtl/serial_full_subtractor.sv
// Bit-serial subtractor: one full subtractor (two half subtractors + OR) walks the
// operands LSB first over WIDTH cycles and publishes Diff/Borrow only when complete.
module serial_full_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Borrow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Returns {borrow, difference} of x - y.
    function automatic logic [1:0] half_sub(input logic x, input logic y);
        half_sub = {~x & y, x ^ y};
    endfunction

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d, borrow_q, borrow_d, busy_q, busy_d, done_q, done_d;

    logic             hs1_b_s, hs1_d_s, hs2_b_s, bit_d_s, br_next_s;

    assign {hs1_b_s, hs1_d_s} = half_sub(a_q[0], b_q[0]);
    assign {hs2_b_s, bit_d_s} = half_sub(hs1_d_s, br_q);
    assign br_next_s          = hs1_b_s | hs2_b_s;

    // Next-state, datapath and output-register logic.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        br_d     = br_q;
        res_d    = res_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                // DONE accepts a new start directly so back-to-back runs lose no cycle.
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    br_d    = Bin;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                a_d   = {1'b0, a_q[WIDTH-1:1]};
                b_d   = {1'b0, b_q[WIDTH-1:1]};
                br_d  = br_next_s;
                res_d = {bit_d_s, res_q[WIDTH-1:1]};
                cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                if (cnt_q == LAST_BIT) begin
                    diff_d   = {bit_d_s, res_q[WIDTH-1:1]};
                    borrow_d = br_next_s;
                    state_d  = ST_DONE;
                end else begin
                    state_d  = ST_SHIFT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_SHIFT);
        done_d = (state_d == ST_DONE);
    end

    // State and result registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            br_q     <= 1'b0;
            res_q    <= '0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            br_q     <= br_d;
            res_q    <= res_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign Diff   = diff_q;
    assign Borrow = borrow_q;

endmodule

// File: tb/tb_serial_full_subtractor.sv
// Scoreboard bench: an 8-bit instance for directed/random/back-to-back/reset cases and
// a 4-bit instance swept over every operand combination.
module tb_serial_full_subtractor;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       s8, bi8, busy8, done8, bo8;
    logic [7:0] a8, b8, d8;
    logic       s4, bi4, busy4, done4, bo4;
    logic [3:0] a4, b4, d4;

    serial_full_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(s8), .A(a8), .B(b8), .Bin(bi8),
        .busy(busy8), .done(done8), .Diff(d8), .Borrow(bo8));

    serial_full_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(s4), .A(a4), .B(b4), .Bin(bi4),
        .busy(busy4), .done(done4), .Diff(d4), .Borrow(bo4));

    typedef struct {
        int diff;
        int borrow;
        int cyc;
    } exp_t;

    exp_t q8[$];
    exp_t q4[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   last8 = 0;
    int   brun8 = 0;
    int   brun4 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic, wrapped to w bits.
    function automatic exp_t model(input int w, input int a, input int b, input int bin, input int c);
        exp_t m;
        int   t;
        t        = a - b - bin;
        m.diff   = t & ((1 << w) - 1);
        m.borrow = (t < 0) ? 1 : 0;
        m.cyc    = c;
        return m;
    endfunction

    // Monitor for the 8-bit instance.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            brun8 = 0;
        end else begin
            if (busy8) begin
                brun8++;
                chk("diff_hold_in_shift", int'(d8), last8);
            end
            if (done8) begin
                chk("busy_length8", brun8, 8);
                brun8 = 0;
                if (q8.size() == 0) begin
                    chk("unexpected_done8", 1, 0);
                end else begin
                    e = q8.pop_front();
                    chk("diff8", int'(d8), e.diff);
                    chk("borrow8", int'(bo8), e.borrow);
                    chk("latency8", cyc - e.cyc, 9);
                    last8 = e.diff;
                end
            end
        end
    end

    // Monitor for the 4-bit instance.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            brun4 = 0;
        end else begin
            if (busy4) brun4++;
            if (done4) begin
                chk("busy_length4", brun4, 4);
                brun4 = 0;
                if (q4.size() == 0) begin
                    chk("unexpected_done4", 1, 0);
                end else begin
                    e = q4.pop_front();
                    chk("diff4", int'(d4), e.diff);
                    chk("borrow4", int'(bo4), e.borrow);
                    chk("latency4", cyc - e.cyc, 5);
                end
            end
        end
    end

    task automatic wait_done(input bit is8);
        int k;
        for (k = 0; k < 40; k++) begin
            @(negedge clk);
            if (is8 ? done8 : done4) break;
        end
        if (k == 40) chk(is8 ? "timeout8" : "timeout4", 1, 0);
    endtask

    // One isolated operation; operands are scrambled right after acceptance.
    task automatic op(input bit is8, input int a, input int b, input int bin);
        @(negedge clk);
        if (is8) begin
            s8 = 1'b1; a8 = 8'(a); b8 = 8'(b); bi8 = 1'(bin);
        end else begin
            s4 = 1'b1; a4 = 4'(a); b4 = 4'(b); bi4 = 1'(bin);
        end
        @(posedge clk);
        if (is8) q8.push_back(model(8, a, b, bin, cyc));
        else     q4.push_back(model(4, a, b, bin, cyc));
        #1;
        s8 = 1'b0; s4 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); bi8 = 1'($urandom);
        a4 = 4'($urandom); b4 = 4'($urandom); bi4 = 1'($urandom);
        wait_done(is8);
    endtask

    // Start held high: one acceptance every 9 cycles, operands garbage in between.
    task automatic back_to_back(input int n);
        int a, b, bin;
        for (int i = 0; i < n; i++) begin
            a = int'($urandom_range(255, 0)); b = int'($urandom_range(255, 0));
            bin = int'($urandom_range(1, 0));
            @(negedge clk);
            s8 = 1'b1; a8 = 8'(a); b8 = 8'(b); bi8 = 1'(bin);
            @(posedge clk);
            q8.push_back(model(8, a, b, bin, cyc));
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                a8 = 8'($urandom); b8 = 8'($urandom); bi8 = 1'($urandom);
            end
        end
        @(negedge clk);
        s8 = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        s8 = 1'b0; a8 = 8'h00; b8 = 8'h00; bi8 = 1'b0;
        s4 = 1'b0; a4 = 4'h0; b4 = 4'h0; bi4 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy8", int'(busy8), 0);
        chk("rst_done8", int'(done8), 0);
        chk("rst_diff8", int'(d8), 0);
        chk("rst_borrow8", int'(bo8), 0);
        chk("rst_busy4", int'(busy4), 0);
        chk("rst_diff4", int'(d4), 0);
        rst_n = 1'b1;

        op(1'b1, 8'h5A, 8'h23, 0);
        op(1'b1, 8'h01, 8'h02, 0);
        op(1'b1, 8'h00, 8'h01, 0);
        op(1'b1, 8'h10, 8'h10, 1);
        op(1'b1, 8'hFF, 8'h00, 1);
        op(1'b1, 8'hFF, 8'hFF, 1);
        for (int i = 0; i < 30; i++)
            op(1'b1, int'($urandom_range(255, 0)), int'($urandom_range(255, 0)),
               int'($urandom_range(1, 0)));

        back_to_back(4);

        // Abort in the 4th SHIFT cycle.
        @(negedge clk);
        s8 = 1'b1; a8 = 8'h77; b8 = 8'h11; bi8 = 1'b0;
        @(posedge clk);
        #1 s8 = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy8", int'(busy8), 0);
        chk("abort_done8", int'(done8), 0);
        chk("abort_diff8", int'(d8), 0);
        chk("abort_borrow8", int'(bo8), 0);
        q8.delete();
        last8 = 0;
        #10 rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("no_done_after_abort", int'(done8), 0);
        op(1'b1, 8'h34, 8'h12, 1);

        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int bin = 0; bin < 2; bin++)
                    op(1'b0, a, b, bin);

        repeat (5) @(negedge clk);
        chk("q8_drained", q8.size(), 0);
        chk("q4_drained", q4.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
